midi_writer: RTL and testbench



---
 rtl/midi_pkg.sv | 37 +++
 rtl/uart_byte_tx.sv | 64 ++++++
 rtl/midi_writer.sv | 121 ++++++++++++
 tb/tb_midi_writer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI definitions: channel-message status nibbles, message lengths
// and the state encodings used by the writer and its byte serialiser.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF         = 4'h8;
  localparam logic [3:0] NOTE_ON          = 4'h9;
  localparam logic [3:0] POLY_PRESSURE    = 4'hA;
  localparam logic [3:0] CONTROL_CHANGE   = 4'hB;
  localparam logic [3:0] PROGRAM_CHANGE   = 4'hC;
  localparam logic [3:0] CHANNEL_PRESSURE = 4'hD;
  localparam logic [3:0] PITCH_BEND       = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STATUS,
    ST_D1,
    ST_D2,
    ST_DONE
  } writer_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Bytes on the wire for a status nibble, status byte included; 0 = drop.
  function automatic logic [1:0] msg_len(input logic [3:0] status);
    case (status)
      NOTE_OFF, NOTE_ON, POLY_PRESSURE, CONTROL_CHANGE, PITCH_BEND: msg_len = 2'd3;
      PROGRAM_CHANGE, CHANNEL_PRESSURE:                             msg_len = 2'd2;
      default:                                                      msg_len = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// UART 8N1 byte serialiser. ready_out rises during the final stop-bit cycle
// so a follow-on byte can be loaded with no idle gap on the line.
module uart_byte_tx
  import midi_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_wire_out
);

  localparam int CNT_W = $clog2(CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CYCLES_PER_BIT - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= TX_IDLE;
      cnt     <= RELOAD;
      shift   <= '0;
      bit_idx <= '0;
    end else if (valid_in && ready_out) begin
      state   <= TX_START;
      cnt     <= RELOAD;
      shift   <= byte_in;
      bit_idx <= '0;
    end else if (state != TX_IDLE) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= RELOAD;
        case (state)
          TX_START: state <= TX_DATA;
          TX_DATA: begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= TX_STOP;
          end
          default: state <= TX_IDLE;
        endcase
      end
    end
  end

  assign ready_out = (state == TX_IDLE) || ((state == TX_STOP) && (cnt == '0));

  always_comb begin
    tx_wire_out = 1'b1;
    case (state)
      TX_START: tx_wire_out = 1'b0;
      TX_DATA:  tx_wire_out = shift[0];
      default:  tx_wire_out = 1'b1;
    endcase
  end

endmodule

// File: rtl/midi_writer.sv
// MIDI channel-message transmitter: frames one handshaked message as 2 or 3
// bytes (with optional running status) and streams them via uart_byte_tx.
module midi_writer
  import midi_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int BAUD           = 31250,
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] status,
  input  logic [3:0] channel,
  input  logic [7:0] data_byte1,
  input  logic [7:0] data_byte2,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_wire_out,
  output logic       busy_out,
  output logic       done_out
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BAUD;

  writer_state_t state, state_next;
  logic [7:0] d1_q, d2_q, rs_byte, tx_byte, status_byte;
  logic [1:0] len_q, in_len;
  logic       rs_valid, skip, accept, tx_valid, tx_ready;

  assign status_byte = {status, channel};
  assign in_len      = msg_len(status);
  assign skip        = RUNNING_STATUS && rs_valid && (rs_byte == status_byte);

  assign ready_out = (state == ST_IDLE) || (state == ST_DONE);
  assign busy_out  = !ready_out;
  assign done_out  = (state == ST_DONE);

  // The first byte is launched on the accepting edge itself so its start bit
  // appears one cycle after acceptance; later bytes chain on tx_ready.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    tx_valid   = 1'b0;
    tx_byte    = '0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        if (valid_in) begin
          accept = 1'b1;
          if (in_len == 2'd0) begin
            state_next = ST_DONE;
          end else if (skip) begin
            tx_valid   = 1'b1;
            tx_byte    = data_byte1 & 8'h7F;
            state_next = ST_D1;
          end else begin
            tx_valid   = 1'b1;
            tx_byte    = status_byte;
            state_next = ST_STATUS;
          end
        end
      end
      ST_STATUS: begin
        if (tx_ready) begin
          tx_valid   = 1'b1;
          tx_byte    = d1_q;
          state_next = ST_D1;
        end
      end
      ST_D1: begin
        if (tx_ready) begin
          if (len_q == 2'd3) begin
            tx_valid   = 1'b1;
            tx_byte    = d2_q;
            state_next = ST_D2;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_D2: begin
        if (tx_ready) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= ST_IDLE;
      d1_q     <= '0;
      d2_q     <= '0;
      len_q    <= '0;
      rs_valid <= 1'b0;
      rs_byte  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        d1_q  <= data_byte1 & 8'h7F;
        d2_q  <= data_byte2 & 8'h7F;
        len_q <= in_len;
        if (in_len != 2'd0 && !skip) begin
          rs_valid <= 1'b1;
          rs_byte  <= status_byte;
        end
      end
    end
  end

  uart_byte_tx #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_uart_byte_tx (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .byte_in    (tx_byte),
    .valid_in   (tx_valid),
    .ready_out  (tx_ready),
    .tx_wire_out(tx_wire_out)
  );

endmodule

// File: tb/tb_midi_writer.sv
// Directed self-checking bench for midi_writer at 4 clocks per bit; every
// line cycle is compared against the hand-chosen byte sequence of each step.
module tb_midi_writer;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [3:0] status, channel;
  logic [7:0] data_byte1, data_byte2;
  logic       valid_in;
  logic       ready_out, tx_wire_out, busy_out, done_out;

  int checks   = 0;
  int failures = 0;

  midi_writer #(
    .CLK_HZ(400),
    .BAUD(100),
    .RUNNING_STATUS(1'b1)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .status     (status),
    .channel    (channel),
    .data_byte1 (data_byte1),
    .data_byte2 (data_byte2),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .tx_wire_out(tx_wire_out),
    .busy_out   (busy_out),
    .done_out   (done_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] st, input logic [3:0] ch,
                               input logic [7:0] b1, input logic [7:0] b2);
    status     = st;
    channel    = ch;
    data_byte1 = b1;
    data_byte2 = b2;
    valid_in   = 1'b1;
    step();
    valid_in   = 1'b0;
  endtask

  // Walks nbits bits of an 8N1 frame; optionally pulses valid_in mid-byte.
  task automatic checkByte(input logic [7:0] b, input bit pulse, input int nbits);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < 4; c++) begin
        checkOutput($sformatf("line_%02h_bit%0d_c%0d", b, i, c), 32'(tx_wire_out),
                    32'(frame[i]));
        if (c == 0) begin
          checkOutput($sformatf("ready_low_%02h_bit%0d", b, i), 32'(ready_out), 32'd0);
          checkOutput($sformatf("busy_high_%02h_bit%0d", b, i), 32'(busy_out), 32'd1);
        end
        if (pulse && i == 4 && c == 1) valid_in = 1'b1;
        if (pulse && i == 4 && c == 2) valid_in = 1'b0;
        step();
      end
    end
  endtask

  task automatic checkDone(input string tag);
    checkOutput({tag, "_done"}, 32'(done_out), 32'd1);
    checkOutput({tag, "_ready"}, 32'(ready_out), 32'd1);
    checkOutput({tag, "_line"}, 32'(tx_wire_out), 32'd1);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_done_clr"}, 32'(done_out), 32'd0);
    checkOutput({tag, "_idle_line"}, 32'(tx_wire_out), 32'd1);
    checkOutput({tag, "_idle_busy"}, 32'(busy_out), 32'd0);
  endtask

  initial begin
    rst_in = 1'b1;
    valid_in = 1'b0;
    status = '0;
    channel = '0;
    data_byte1 = '0;
    data_byte2 = '0;
    step();
    step();
    checkOutput("rst_line", 32'(tx_wire_out), 32'd1);
    checkOutput("rst_ready", 32'(ready_out), 32'd1);
    checkOutput("rst_busy", 32'(busy_out), 32'd0);
    checkOutput("rst_done", 32'(done_out), 32'd0);
    rst_in = 1'b0;
    step();

    $display("[TB] note-on ch0");
    applyStimulus(4'h9, 4'h0, 8'h3C, 8'h64);
    checkByte(8'h90, 1'b0, 10);
    checkByte(8'h3C, 1'b0, 10);
    checkByte(8'h64, 1'b0, 10);
    checkDone("noteon");
    step();
    checkIdle("noteon");

    $display("[TB] program change, bit 7 masked");
    applyStimulus(4'hC, 4'h5, 8'h8A, 8'hFF);
    checkByte(8'hC5, 1'b0, 10);
    checkByte(8'h0A, 1'b0, 10);
    checkDone("progchg");
    step();
    checkIdle("progchg");

    $display("[TB] running status on ch3");
    applyStimulus(4'h9, 4'h3, 8'h40, 8'h7F);
    checkByte(8'h93, 1'b0, 10);
    checkByte(8'h40, 1'b0, 10);
    checkByte(8'h7F, 1'b0, 10);
    checkDone("rs_first");
    step();
    applyStimulus(4'h9, 4'h3, 8'h41, 8'h20);
    checkByte(8'h41, 1'b0, 10);
    checkByte(8'h20, 1'b0, 10);
    checkDone("rs_skip");
    step();
    applyStimulus(4'h8, 4'h3, 8'h40, 8'h00);
    checkByte(8'h83, 1'b0, 10);
    checkByte(8'h40, 1'b0, 10);
    checkByte(8'h00, 1'b0, 10);
    checkDone("noteoff");
    step();
    checkIdle("noteoff");

    $display("[TB] back-to-back with valid held");
    status = 4'h9; channel = 4'h3; data_byte1 = 8'h10; data_byte2 = 8'h20;
    valid_in = 1'b1;
    step();
    data_byte1 = 8'h11; data_byte2 = 8'h22;
    checkByte(8'h93, 1'b0, 10);
    checkByte(8'h10, 1'b0, 10);
    checkByte(8'h20, 1'b0, 10);
    checkDone("b2b_first");
    step();
    valid_in = 1'b0;
    status = 4'hE; channel = 4'h7;
    checkByte(8'h11, 1'b1, 10);
    checkByte(8'h22, 1'b1, 10);
    checkDone("b2b_second");
    step();
    checkIdle("b2b");

    $display("[TB] invalid status dropped");
    applyStimulus(4'hF, 4'h3, 8'h55, 8'h66);
    checkDone("drop");
    checkOutput("drop_busy", 32'(busy_out), 32'd0);
    step();
    checkIdle("drop");
    applyStimulus(4'h9, 4'h3, 8'h12, 8'h23);
    checkByte(8'h12, 1'b0, 10);
    checkByte(8'h23, 1'b0, 10);
    checkDone("drop_rs_kept");
    step();

    $display("[TB] reset mid second byte");
    applyStimulus(4'hE, 4'h1, 8'h00, 8'h40);
    checkByte(8'hE1, 1'b0, 10);
    checkByte(8'h00, 1'b0, 5);
    rst_in = 1'b1;
    step();
    checkOutput("midrst_line", 32'(tx_wire_out), 32'd1);
    checkOutput("midrst_ready", 32'(ready_out), 32'd1);
    checkOutput("midrst_busy", 32'(busy_out), 32'd0);
    checkOutput("midrst_done", 32'(done_out), 32'd0);
    rst_in = 1'b0;
    applyStimulus(4'hE, 4'h1, 8'h00, 8'h40);
    checkByte(8'hE1, 1'b0, 10);
    checkByte(8'h00, 1'b0, 10);
    checkByte(8'h40, 1'b0, 10);
    checkDone("postrst");
    step();
    checkIdle("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
